// File: rtl/dmem_line_responder.sv
// Line-granular data memory answering the data cache's fill/write-back handshake.
// A captured request waits LATENCY cycles, then commits or returns a line with a one-cycle ack.
//
//   state  | meaning
//   IDLE   | waiting for enable_i
//   BUSY   | latency countdown on the latched request
//   ACK    | ack_o high; a held enable_i is captured on the edge leaving this state
module dmem_line_responder #(
   parameter int LATENCY    = 10,
   parameter int DEPTH_LOG2 = 9
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         enable_i,
   input  logic         write_i,
   input  logic [31:0]  addr_i,
   input  logic [255:0] data_i,
   output logic         ack_o,
   output logic [255:0] data_o
);

   localparam int         DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_ACK  = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [7:0]            cnt_q, cnt_d;
   logic                  wr_q, wr_d;
   logic [DEPTH_LOG2-1:0] idx_q, idx_d;
   logic [255:0]          wdata_q, wdata_d;
   logic [255:0]          rdata_q, rdata_d;
   logic [DEPTH_LOG2-1:0] req_idx;
   logic                  mem_we;
   logic                  unused_addr;

   logic [255:0] mem_q [DEPTH];

   // Upper address bits alias; the byte offset within the line is irrelevant.
   assign req_idx     = addr_i[DEPTH_LOG2+4:5];
   assign unused_addr = ^{addr_i[31:DEPTH_LOG2+5], addr_i[4:0]};

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         idx_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = wr_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         S_IDLE, S_ACK: begin
            state_d = S_IDLE;
            if (enable_i) begin
               state_d = S_BUSY;
               cnt_d   = CNT_LOAD;
               wr_d    = write_i;
               idx_d   = req_idx;
               wdata_d = data_i;
            end
         end
         S_BUSY: begin
            if (cnt_q != 8'd0) begin
               cnt_d = cnt_q - 8'd1;
            end else begin
               state_d = S_ACK;
               if (!wr_q) begin
                  rdata_d = mem_q[idx_q];
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ack_o  = (state_q == S_ACK);
      data_o = rdata_q;
      mem_we = (state_q == S_BUSY) && (cnt_q == 8'd0) && wr_q;
   end

   // Array has no reset so its contents survive rst_i.
   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         mem_q[idx_q] <= wdata_q;
      end
   end

endmodule

// File: tb/tb_dmem_line_responder.sv
// Directed bench for dmem_line_responder: a LATENCY=10 instance and a LATENCY=1 instance,
// with a scoreboard of expected ack cycle and data_o per transaction.
module tb_dmem_line_responder;

   localparam int LAT  = 10;
   localparam int LAT1 = 1;

   logic         clk_i = 1'b0;
   logic         rst_i = 1'b0;

   logic         en = 1'b0, wr = 1'b0;
   logic [31:0]  addr = '0;
   logic [255:0] din = '0;
   logic         ack;
   logic [255:0] dout;

   logic         en1 = 1'b0, wr1 = 1'b0;
   logic [31:0]  addr1 = '0;
   logic [255:0] din1 = '0;
   logic         ack1;
   logic [255:0] dout1;

   typedef struct {
      logic [255:0] dout;
      int           ack_cyc;
   } exp_t;

   exp_t         sb[$];
   exp_t         sb1[$];
   logic [255:0] mdl_dout  = '0;
   logic [255:0] mdl_dout1 = '0;
   int           cyc = 0;
   int           checks = 0;
   int           failures = 0;

   dmem_line_responder #(.LATENCY(LAT), .DEPTH_LOG2(9)) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .enable_i(en),
      .write_i (wr),
      .addr_i  (addr),
      .data_i  (din),
      .ack_o   (ack),
      .data_o  (dout)
   );

   dmem_line_responder #(.LATENCY(LAT1), .DEPTH_LOG2(9)) dut1 (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .enable_i(en1),
      .write_i (wr1),
      .addr_i  (addr1),
      .data_i  (din1),
      .ack_o   (ack1),
      .data_o  (dout1)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog expired cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Every ack must match the oldest outstanding expectation in cycle and data.
   always @(negedge clk_i) begin
      if (ack === 1'b1) begin
         exp_t e;
         chk("ack_expected", 256'(sb.size() != 0), 256'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("ack_cycle", 256'(cyc), 256'(e.ack_cyc));
            chk("ack_data", dout, e.dout);
         end
      end
   end

   always @(negedge clk_i) begin
      if (ack1 === 1'b1) begin
         exp_t e;
         chk("l1_ack_expected", 256'(sb1.size() != 0), 256'd1);
         if (sb1.size() != 0) begin
            e = sb1.pop_front();
            chk("l1_ack_cycle", 256'(cyc), 256'(e.ack_cyc));
            chk("l1_ack_data", dout1, e.dout);
         end
      end
   end

   // Drives a request in the current cycle; capture is the next rising edge.
   task automatic drive(input logic w, input logic [31:0] a, input logic [255:0] d,
                        input logic [255:0] rd_exp);
      exp_t e;
      en   = 1'b1;
      wr   = w;
      addr = a;
      din  = d;
      if (!w) mdl_dout = rd_exp;
      e.dout    = mdl_dout;
      e.ack_cyc = cyc + 1 + LAT;
      sb.push_back(e);
   endtask

   task automatic issue(input logic w, input logic [31:0] a, input logic [255:0] d,
                        input logic [255:0] rd_exp);
      @(negedge clk_i);
      drive(w, a, d, rd_exp);
   endtask

   task automatic wait_ack();
      bit got = 1'b0;
      for (int i = 0; i < LAT + 8 && !got; i++) begin
         @(negedge clk_i);
         if (ack === 1'b1) got = 1'b1;
      end
      if (!got) chk("ack_timeout", 256'd0, 256'd1);
   endtask

   task automatic txn(input logic w, input logic [31:0] a, input logic [255:0] d,
                      input logic [255:0] rd_exp);
      issue(w, a, d, rd_exp);
      @(negedge clk_i);
      en = 1'b0;
      wait_ack();
   endtask

   function automatic logic [255:0] rnd256();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   initial begin
      logic [255:0] pat_a5, pat_11, pat_22, pat_33, pat_ff, pat_db;
      logic [255:0] d1;
      pat_a5 = {32{8'hA5}};
      pat_11 = {32{8'h11}};
      pat_22 = {32{8'h22}};
      pat_33 = {32{8'h33}};
      pat_ff = {256{1'b1}};
      pat_db = {8{32'hDEADBEEF}};

      repeat (2) @(negedge clk_i);
      chk("reset_ack", 256'(ack), 256'd0);
      chk("reset_data", dout, 256'd0);
      chk("reset_ack_l1", 256'(ack1), 256'd0);
      chk("reset_data_l1", dout1, 256'd0);
      rst_i = 1'b1;
      repeat (2) @(negedge clk_i);

      // Write then read through a different byte offset of the same line.
      txn(1'b1, 32'h0000_0400, pat_a5, '0);
      txn(1'b0, 32'h0000_041F, '0, pat_a5);

      // Write-back then fill with enable_i held across the ACK cycle.
      txn(1'b1, 32'h0000_0C00, pat_22, '0);
      issue(1'b1, 32'h0000_0800, pat_11, '0);
      wait_ack();
      drive(1'b0, 32'h0000_0C00, '0, pat_22);
      @(negedge clk_i);
      en = 1'b0;
      wait_ack();
      txn(1'b0, 32'h0000_0800, '0, pat_11);

      // Inputs changing mid-transaction must not disturb the latched request.
      issue(1'b0, 32'h0000_0400, '0, pat_a5);
      repeat (3) @(negedge clk_i);
      addr = 32'h0000_0800;
      en   = 1'b0;
      wait_ack();
      repeat (15) @(negedge clk_i);

      // Reset in the middle of a write: no ack, no array update.
      txn(1'b1, 32'h0000_0600, pat_33, '0);
      issue(1'b1, 32'h0000_0600, pat_ff, '0);
      void'(sb.pop_back());
      repeat (4) @(negedge clk_i);
      #2;
      rst_i = 1'b0;
      en    = 1'b0;
      mdl_dout  = '0;
      mdl_dout1 = '0;
      @(negedge clk_i);
      chk("midrst_ack", 256'(ack), 256'd0);
      chk("midrst_data", dout, 256'd0);
      rst_i = 1'b1;
      repeat (15) @(negedge clk_i);
      chk("midrst_data_hold", dout, 256'd0);
      txn(1'b0, 32'h0000_0600, '0, pat_33);

      // Upper address bits alias onto the same line.
      txn(1'b1, 32'h0000_4000, pat_db, '0);
      txn(1'b0, 32'h0000_0000, '0, pat_db);

      // LATENCY=1: alternating write/read, enable held, new request every 2 cycles.
      @(negedge clk_i);
      for (int k = 0; k < 6; k++) begin
         exp_t e;
         d1 = rnd256();
         en1   = 1'b1;
         wr1   = 1'b1;
         addr1 = 32'(k) * 32'h20 + 32'h100;
         din1  = d1;
         e.dout    = mdl_dout1;
         e.ack_cyc = cyc + 1 + LAT1;
         sb1.push_back(e);
         repeat (2) @(negedge clk_i);
         wr1   = 1'b0;
         din1  = '0;
         mdl_dout1 = d1;
         e.dout    = mdl_dout1;
         e.ack_cyc = cyc + 1 + LAT1;
         sb1.push_back(e);
         repeat (2) @(negedge clk_i);
      end
      en1 = 1'b0;
      repeat (6) @(negedge clk_i);

      chk("sb_drained", 256'(sb.size()), 256'd0);
      chk("sb1_drained", 256'(sb1.size()), 256'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
